// File: rtl/micro_pkg.sv
// Shared definitions for the micro and its program loader: data/address
// width defaults, the load-frame header byte and the loader FSM states.
package micro_pkg;

  localparam int unsigned MICRO_WIDTH     = 8;
  localparam int unsigned MICRO_N_ADDRESS = 8;
  localparam logic [7:0]  MICRO_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } ld_state_t;

endpackage

// File: rtl/checksum_acc.sv
// Modulo-2**WIDTH byte accumulator for the load-frame checksum.
// zero reports whether the stored sum plus the byte currently on data
// wraps to zero, so the loader can judge the checksum byte on the same
// edge it accepts it.
module checksum_acc
  import micro_pkg::*;
#(
  parameter int unsigned WIDTH = MICRO_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic             zero
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] total;

  // Running sum; clear dominates enable.
  always_ff @(posedge clk) begin
    if (clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + data;
    end
  end

  // Sum including the byte on the input, checked against zero.
  always_comb begin
    total = sum + data;
    zero  = (total == '0);
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses SYNC / LEN / DATA... / CHK frames from a byte
// stream, writes the payload into program memory from address 0 and holds
// the micro in reset until a frame with a good checksum has been loaded.
module prog_loader
  import micro_pkg::*;
#(
  parameter int unsigned      WIDTH     = MICRO_WIDTH,
  parameter int unsigned      N_ADDRESS = MICRO_N_ADDRESS,
  parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(MICRO_SYNC_BYTE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 start,
  output logic [N_ADDRESS-1:0] rom_wr_addr,
  output logic [WIDTH-1:0]     rom_wr_data,
  output logic                 rom_wr_en,
  output logic                 cpu_rst,
  output logic                 done,
  output logic                 error
);

  localparam logic [N_ADDRESS-1:0] ADDR_ONE = N_ADDRESS'(1);

  ld_state_t            state;
  logic [N_ADDRESS-1:0] addr;
  logic [N_ADDRESS-1:0] last_addr;
  logic                 accept;
  logic                 is_last;
  logic                 acc_clear;
  logic                 acc_en;
  logic                 chk_zero;

  // Handshake and accumulator control decoded from the current state.
  always_comb begin
    accept    = in_valid && in_ready;
    is_last   = (addr == last_addr);
    acc_clear = rst || ((state == ST_LEN) && accept);
    acc_en    = (state == ST_DATA) && accept;
  end

  checksum_acc #(
    .WIDTH (WIDTH)
  ) u_checksum_acc (
    .clk   (clk),
    .clear (acc_clear),
    .en    (acc_en),
    .data  (in_data),
    .zero  (chk_zero)
  );

  // Frame FSM with registered handshake, write port and status outputs.
  // Length L is stored as the last address L-1, so L=0 maps to all-ones and
  // a full 2**N_ADDRESS image ends at the top address without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_SYNC;
      in_ready    <= 1'b1;
      rom_wr_en   <= 1'b0;
      rom_wr_addr <= '0;
      rom_wr_data <= '0;
      cpu_rst     <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      addr        <= '0;
      last_addr   <= '0;
    end else begin
      rom_wr_en <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (accept) begin
            last_addr <= N_ADDRESS'(in_data) - ADDR_ONE;
            addr      <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            rom_wr_en   <= 1'b1;
            rom_wr_addr <= addr;
            rom_wr_data <= in_data;
            if (is_last) begin
              state <= ST_CHK;
            end else begin
              addr <= addr + ADDR_ONE;
            end
          end
        end
        ST_CHK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (chk_zero) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_SYNC;
            in_ready <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_rst  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_SYNC;
          in_ready <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b0;
          cpu_rst  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random frames with
// random bubbles, checked against a stream-level model of the frame rules.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       start;
  logic [7:0] rom_wr_addr;
  logic [7:0] rom_wr_data;
  logic       rom_wr_en;
  logic       cpu_rst;
  logic       done;
  logic       error;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [15:0] got_q[$];
  logic [7:0]  stream[$];

  prog_loader #(
    .WIDTH     (8),
    .N_ADDRESS (8),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .start       (start),
    .rom_wr_addr (rom_wr_addr),
    .rom_wr_data (rom_wr_data),
    .rom_wr_en   (rom_wr_en),
    .cpu_rst     (cpu_rst),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Write log: every strobed cycle is one write.
  always @(negedge clk) begin
    if (rom_wr_en) got_q.push_back({rom_wr_addr, rom_wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Frame rules applied to the whole stream: skip to the first header,
  // next byte is the length (0 = 256), then payload, then checksum.
  task automatic model(output int s, output int n, output bit pass);
    int sum;
    s = -1;
    for (int i = 0; i < stream.size(); i++) begin
      if (stream[i] == 8'hA5) begin
        s = i;
        break;
      end
    end
    n = (stream[s+1] == 8'h00) ? 256 : int'(stream[s+1]);
    sum = 0;
    for (int k = 0; k < n; k++) sum += int'(stream[s+2+k]);
    pass = ((sum + int'(stream[s+2+n])) % 256) == 0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int w;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = in_ready;
    if (!ok) begin
      chk("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input bit bubbles);
    int s, n, bad;
    bit pass, ok, is_data;
    model(s, n, pass);
    got_q.delete();
    for (int i = 0; i < stream.size(); i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          start    = ($urandom_range(0, 3) == 0);
        end
      end
      send_byte(stream[i], ok);
      if (!ok) return;
      is_data = (i >= s + 2) && (i < s + 2 + n);
      chk("wr_en", 32'(rom_wr_en), 32'(is_data));
      if (is_data) begin
        chk("wr_addr", 32'(rom_wr_addr), 32'(i - s - 2));
        chk("wr_data", 32'(rom_wr_data), 32'(stream[i]));
      end
      if (i < stream.size() - 1) chk("cpu_rst_busy", 32'(cpu_rst), 32'd1);
    end
    chk("done", 32'(done), 32'(pass));
    chk("error", 32'(error), 32'(!pass));
    chk("cpu_rst_end", 32'(cpu_rst), 32'(!pass));
    chk("in_ready_end", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("n_writes", 32'(got_q.size()), 32'(n));
    bad = 0;
    if (got_q.size() == n) begin
      for (int k = 0; k < n; k++) begin
        if (got_q[k] !== {8'(k), stream[s+2+k]}) bad++;
      end
    end
    chk("write_log", 32'(bad), 32'd0);
    // Loader must ignore the link once finished.
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_no_write", 32'(got_q.size()), 32'(n));
    chk("idle_done", 32'(done), 32'(pass));
  endtask

  task automatic rearm();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("rearm_ready", 32'(in_ready), 32'd1);
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_error", 32'(error), 32'd0);
    chk("rearm_cpu_rst", 32'(cpu_rst), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int len, sum;
    logic [7:0] b;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_en", 32'(rom_wr_en), 32'd0);
    chk("rst_addr", 32'(rom_wr_addr), 32'd0);
    chk("rst_data", 32'(rom_wr_data), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Good three-byte frame.
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    run_stream(1'b0);
    rearm();

    // Bad checksum.
    stream = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    run_stream(1'b0);
    rearm();

    // Junk before the header is discarded.
    stream = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7F, 8'h81};
    run_stream(1'b0);
    rearm();

    // Full 256-byte image, last write at FF.
    stream = '{8'hA5, 8'h00};
    repeat (256) stream.push_back(8'h01);
    stream.push_back(8'h00);
    run_stream(1'b1);
    chk("full_last_addr", 32'(got_q.size() == 256 ? got_q[255][15:8] : 8'h00), 32'hFF);
    rearm();

    // Reset in the middle of the payload, same edge as a valid byte.
    got_q.delete();
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22};
    foreach (stream[i]) send_byte(stream[i], ok);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h33; start = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_wr_en", 32'(rom_wr_en), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_writes", 32'(got_q.size()), 32'd2);
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    run_stream(1'b0);
    rearm();

    // Same frame with bubbles and stray start pulses.
    repeat (4) begin
      stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
      run_stream(1'b1);
      rearm();
    end

    // Random frames.
    repeat (20) begin
      stream.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        stream.push_back(b);
      end
      stream.push_back(8'hA5);
      len = $urandom_range(1, 24);
      stream.push_back(8'(len));
      sum = 0;
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        sum += int'(b);
        stream.push_back(b);
      end
      if ($urandom_range(0, 3) != 0) stream.push_back(8'((256 - (sum % 256)) % 256));
      else stream.push_back(8'((256 - (sum % 256) + 1 + $urandom_range(0, 254)) % 256));
      run_stream(1'b1);
      rearm();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter WIDTH, default 8, data byte width in bits.
REQ-002 Parameter N_ADDRESS, default 8, program memory address width; image holds up to 2**N_ADDRESS bytes.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, header value that opens a load frame.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  WIDTH  byte stream from the host link.
REQ-007 in_valid  input  1  in_data holds a valid byte.
REQ-008 in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a clock edge.
REQ-009 start  input  1  one-cycle pulse that re-arms the loader from DONE or ERR.
REQ-010 rom_wr_addr  output  N_ADDRESS  program memory write address.
REQ-011 rom_wr_data  output  WIDTH  program memory write data.
REQ-012 rom_wr_en  output  1  program memory write strobe, one cycle per byte.
REQ-013 cpu_rst  output  1  reset to the micro's arst; high while no verified image is loaded.
REQ-014 done  output  1  verified image loaded.
REQ-015 error  output  1  last frame failed its checksum.

Function
REQ-016 The FSM SHALL have states SYNC, LEN, DATA, CHK, DONE, ERR.
REQ-017 SYNC: in_ready=1; accepted byte == SYNC_BYTE -> LEN; any other byte is discarded and the FSM stays in SYNC.
REQ-018 LEN: in_ready=1; the accepted byte is the length L; L=0 means 2**N_ADDRESS bytes; -> DATA; address counter and checksum accumulator cleared.
REQ-019 DATA: in_ready=1; each accepted byte is written to address 0,1,2,... in order; the accumulator adds the byte mod 2**WIDTH; after the L-th byte -> CHK.
REQ-020 Write timing: the edge after acceptance SHALL present rom_wr_en=1 with the registered address/data for exactly one cycle; latency = 1 cycle; no write occurs for header, length or checksum bytes.
REQ-021 The address counter SHALL be N_ADDRESS bits and SHALL NOT wrap within a frame; with L=0 the final write is at address 2**N_ADDRESS-1.
REQ-022 CHK: in_ready=1; accepted byte C; (accumulator + C) mod 2**WIDTH == 0 -> DONE, otherwise -> ERR.
REQ-023 DONE: in_ready=0, done=1, error=0, cpu_rst=0 from the first cycle in DONE.
REQ-024 ERR: in_ready=0, done=0, error=1, cpu_rst=1.
REQ-025 A start pulse in DONE or ERR SHALL go to SYNC on the next edge, clearing done/error and driving cpu_rst=1; start is ignored in every other state.
REQ-026 cpu_rst SHALL be 1 in SYNC, LEN, DATA and CHK, so the micro never runs a partial image.
REQ-027 in_valid low stalls the FSM in its current state with no side effects; bubbles between bytes are allowed.
REQ-028 in_data/in_valid SHALL be ignored while in_ready=0.

Reset
REQ-029 rst=1 at an edge SHALL force SYNC, in_ready=1, rom_wr_en=0, rom_wr_addr=0, rom_wr_data=0, cpu_rst=1, done=0, error=0, and clear the counter and accumulator.
REQ-030 rst during DATA SHALL abort the frame; a write pending from the prior acceptance SHALL be suppressed; bytes already written stay but are not trusted (cpu_rst=1).
REQ-031 rst has priority over start and in_valid in the same cycle.

Structure
REQ-032 FSM state encodings and the SYNC_BYTE default SHALL live in a shared package micro_pkg, together with the WIDTH/N_ADDRESS defaults the micro uses.
REQ-033 The checksum accumulator SHALL be a separate sub-module, checksum_acc (clear, enable, byte in, zero flag out); everything else stays flat in prog_loader.

Verification
REQ-034 Frame A5,03,11,22,33,9A -> writes 11@0,22@1,33@2 on three one-cycle strobes; done=1, cpu_rst=0 in the cycle after the checksum is accepted.
REQ-035 Frame A5,02,10,20,00 (bad checksum) -> two writes, then error=1, cpu_rst=1, in_ready=0; a start pulse -> SYNC, error=0.
REQ-036 Bytes 00,FF,A5,01,7F,81 -> 00 and FF are discarded, one write 7F@0, done=1.
REQ-037 Frame A5,00, then 256 bytes of 01, checksum 00 -> last write at address FF with no wrap, done=1.
REQ-038 rst asserted after the 2nd of 3 data bytes -> SYNC, no further strobes, cpu_rst=1; a following full valid frame loads correctly.
REQ-039 Random in_valid bubbles on the REQ-034 frame -> identical writes and done=1; the loader ROM image, loaded then checked by the micro running mult_test, gives 0 errors.
